// File: rtl/sync_fifo_flags.sv
// ============================================================================
// sync_fifo_flags: single-clock FIFO with arbitrary depth, occupancy count,
// programmable almost flags, sticky error flags, show-ahead or registered q.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo_flags #(
    parameter int DW        = 24,
    parameter int DEP       = 16,
    parameter int AW        = $clog2(DEP + 1),
    parameter int AF_LVL    = DEP - 2,
    parameter int AE_LVL    = 2,
    parameter int SHOWAHEAD = 1
) (
    input  logic          clock,
    input  logic          aclr,
    input  logic          flush,
    input  logic          wrreq,
    input  logic [DW-1:0] data,
    input  logic          rdreq,
    output logic [DW-1:0] q,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW-1:0] usedw,
    output logic          overflow,
    output logic          underflow
);

    localparam int            PW          = (DEP > 1) ? $clog2(DEP) : 1;
    localparam logic [PW-1:0] C_PTR_LAST  = PW'(DEP - 1);
    localparam logic [AW-1:0] C_DEP       = AW'(DEP);
    localparam logic [AW-1:0] C_AF_LVL    = AW'(AF_LVL);
    localparam logic [AW-1:0] C_AE_LVL    = AW'(AE_LVL);

    generate
        if (DEP < 2 || AF_LVL < 1 || AF_LVL > DEP || AE_LVL < 0 || AE_LVL > DEP - 1) begin : g_bad_params
            $error("sync_fifo_flags: illegal DEP/AF_LVL/AE_LVL combination");
        end
    endgenerate

    logic [DW-1:0] mem [DEP];

    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [AW-1:0] usedw_q, usedw_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          w_wr_ok;
    logic          w_rd_ok;

    // All status flags decode from the registered count only, so they never
    // depend combinationally on the request inputs.
    always_comb begin
        full         = (usedw_q == C_DEP);
        empty        = (usedw_q == '0);
        almost_full  = (usedw_q >= C_AF_LVL);
        almost_empty = (usedw_q <= C_AE_LVL);
        usedw        = usedw_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

    always_comb begin
        w_wr_ok = wrreq & ~full  & ~flush;
        w_rd_ok = rdreq & ~empty & ~flush;
    end

    always_comb begin
        wp_d        = wp_q;
        rp_d        = rp_q;
        usedw_d     = usedw_q;
        overflow_d  = overflow_q  | (wrreq & full);
        underflow_d = underflow_q | (rdreq & empty);

        if (w_wr_ok) begin
            wp_d = (wp_q == C_PTR_LAST) ? '0 : wp_q + PW'(1);
        end
        if (w_rd_ok) begin
            rp_d = (rp_q == C_PTR_LAST) ? '0 : rp_q + PW'(1);
        end

        case ({w_wr_ok, w_rd_ok})
            2'b10:   usedw_d = usedw_q + AW'(1);
            2'b01:   usedw_d = usedw_q - AW'(1);
            default: usedw_d = usedw_q;
        endcase

        // Flush wins over any access in the same cycle.
        if (flush) begin
            wp_d        = '0;
            rp_d        = '0;
            usedw_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            wp_q        <= '0;
            rp_q        <= '0;
            usedw_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            usedw_q     <= usedw_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_ok) begin
            mem[wp_q] <= data;
        end
    end

    generate
        if (SHOWAHEAD != 0) begin : g_showahead
            always_comb begin
                q = mem[rp_q];
            end
        end else begin : g_q_reg
            logic [DW-1:0] q_q, q_d;

            always_comb begin
                q_d = q_q;
                if (w_rd_ok) begin
                    q_d = mem[rp_q];
                end
            end

            always_ff @(posedge clock or posedge aclr) begin
                if (aclr) begin
                    q_q <= '0;
                end else begin
                    q_q <= q_d;
                end
            end

            always_comb begin
                q = q_q;
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
// ============================================================================
// tb_sync_fifo_flags: drives a show-ahead and a registered-q FIFO in lockstep
// and compares both against a queue-based reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo_flags;

    localparam int DW  = 24;
    localparam int DEP = 12;
    localparam int AW  = $clog2(DEP + 1);
    localparam int AFL = 10;
    localparam int AEL = 2;

    logic          clock = 1'b0;
    logic          aclr  = 1'b1;
    logic          flush = 1'b0;
    logic          wrreq = 1'b0;
    logic          rdreq = 1'b0;
    logic [DW-1:0] data  = '0;

    logic [DW-1:0] q_sa, q_rg;
    logic          full_sa, empty_sa, af_sa, ae_sa, ovf_sa, udf_sa;
    logic          full_rg, empty_rg, af_rg, ae_rg, ovf_rg, udf_rg;
    logic [AW-1:0] usedw_sa, usedw_rg;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] m_fifo[$];
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;
    logic [DW-1:0] m_qreg = '0;

    always #5 clock = ~clock;

    sync_fifo_flags #(.DW(DW), .DEP(DEP), .AF_LVL(AFL), .AE_LVL(AEL), .SHOWAHEAD(1)) u_sa (
        .clock(clock), .aclr(aclr), .flush(flush), .wrreq(wrreq), .data(data), .rdreq(rdreq),
        .q(q_sa), .full(full_sa), .empty(empty_sa), .almost_full(af_sa), .almost_empty(ae_sa),
        .usedw(usedw_sa), .overflow(ovf_sa), .underflow(udf_sa)
    );

    sync_fifo_flags #(.DW(DW), .DEP(DEP), .AF_LVL(AFL), .AE_LVL(AEL), .SHOWAHEAD(0)) u_rg (
        .clock(clock), .aclr(aclr), .flush(flush), .wrreq(wrreq), .data(data), .rdreq(rdreq),
        .q(q_rg), .full(full_rg), .empty(empty_rg), .almost_full(af_rg), .almost_empty(ae_rg),
        .usedw(usedw_rg), .overflow(ovf_rg), .underflow(udf_rg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = m_fifo.size();
        chk("usedw_sa", 32'(usedw_sa), 32'(n));
        chk("usedw_rg", 32'(usedw_rg), 32'(n));
        chk("full_sa",  32'(full_sa),  32'(n == DEP));
        chk("full_rg",  32'(full_rg),  32'(n == DEP));
        chk("empty_sa", 32'(empty_sa), 32'(n == 0));
        chk("empty_rg", 32'(empty_rg), 32'(n == 0));
        chk("afull_sa", 32'(af_sa),    32'(n >= AFL));
        chk("afull_rg", 32'(af_rg),    32'(n >= AFL));
        chk("aempty_sa", 32'(ae_sa),   32'(n <= AEL));
        chk("aempty_rg", 32'(ae_rg),   32'(n <= AEL));
        chk("ovf_sa",   32'(ovf_sa),   32'(m_ovf));
        chk("ovf_rg",   32'(ovf_rg),   32'(m_ovf));
        chk("udf_sa",   32'(udf_sa),   32'(m_udf));
        chk("udf_rg",   32'(udf_rg),   32'(m_udf));
        chk("q_rg",     32'(q_rg),     32'(m_qreg));
        if (n > 0) begin
            chk("q_sa", 32'(q_sa), 32'(m_fifo[0]));
        end
    endtask

    // One clock: apply inputs, update the model at the edge, check 1 time unit later.
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
        bit is_full, is_empty;
        wrreq = w; data = d; rdreq = r; flush = f;
        @(posedge clock);
        is_full  = (m_fifo.size() == DEP);
        is_empty = (m_fifo.size() == 0);
        if (f) begin
            m_fifo.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (w && is_full)  m_ovf = 1'b1;
            if (r && is_empty) m_udf = 1'b1;
            if (r && !is_empty) m_qreg = m_fifo.pop_front();
            if (w && !is_full)  m_fifo.push_back(d);
        end
        #1;
        wrreq = 1'b0; rdreq = 1'b0; flush = 1'b0;
        check_all();
    endtask

    task automatic async_reset();
        #3 aclr = 1'b1;
        m_fifo.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_qreg = '0;
        #1;
        check_all();
        #1 aclr = 1'b0;
    endtask

    initial begin
        @(posedge clock);
        #1 aclr = 1'b0;
        async_reset();

        // Fill past full: 12 writes then one rejected write.
        for (int i = 1; i <= DEP + 1; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
        // Concurrent at full: read wins.
        cycle(1'b1, 24'h0000AA, 1'b1, 1'b0);
        // Drain in order across the pointer wrap.
        for (int i = 0; i < DEP; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Concurrent at usedw=5.
        async_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(32'h100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(32'h200 + i), 1'b1, 1'b0);

        // Empty corner and registered-q read timing.
        async_reset();
        cycle(1'b1, 24'hABCDEF, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 24'h000011, 1'b0, 1'b0);
        cycle(1'b1, 24'h000022, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Flush at usedw=7 with overflow set, then the next write is first out.
        async_reset();
        for (int i = 0; i <= DEP; i++) cycle(1'b1, DW'(32'h300 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 24'h00DEAD, 1'b0, 1'b1);
        cycle(1'b1, 24'h00BEEF, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Mid-stream aclr discards stored words.
        for (int i = 0; i < 4; i++) cycle(1'b1, DW'(32'h400 + i), 1'b0, 1'b0);
        async_reset();

        // Randomized traffic with biased fill direction and rare flushes.
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = ((i / 60) % 2 == 0) ? 70 : 30;
            cycle(1'b1 && ($urandom_range(99) < bias),
                  DW'($urandom()),
                  1'b1 && ($urandom_range(99) >= bias),
                  1'b1 && ($urandom_range(63) == 0));
            if ($urandom_range(15) == 0) cycle(1'b1, DW'($urandom()), 1'b1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
